// File: rtl/joy_db15_responder_if.sv
// Host-side serial bus of the DB15 adapter: load strobe and shift clock from
// the host, serial button data back to the host.
interface joy_db15_responder_if;
    logic JOY_LOAD;
    logic JOY_CLK;
    logic JOY_DATA;

    // The host (receiver) drives load and clock and reads data.
    modport master (
        output JOY_LOAD,
        output JOY_CLK,
        input  JOY_DATA
    );

    // The adapter chain samples load and clock and drives data.
    modport slave (
        input  JOY_LOAD,
        input  JOY_CLK,
        output JOY_DATA
    );
endinterface

// File: rtl/joy_db15_responder.sv
// Responder side of the DB15 adapter's serial button chain. Two player button
// words are captured while the host holds JOY_LOAD low and are then shifted out
// on JOY_DATA, one bit per JOY_CLK rising edge, player 1 LSB first.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_LOAD  | chain follows the button image while JOY_LOAD is low
// ST_SHIFT | frame in flight, each JOY_CLK rise shifts and counts
// ST_DONE  | whole chain shifted out, extra edges shift fill and flag overrun
module joy_db15_responder #(
    parameter int unsigned BITS_PER_PLAYER = 12,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter logic        FILL_BIT        = 1'b1,
    localparam int unsigned CHAIN_LEN      = 2 * BITS_PER_PLAYER,
    localparam int unsigned CNT_W          = $clog2(CHAIN_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       RESET_L,
    input  logic [BITS_PER_PLAYER-1:0] joystick1,
    input  logic [BITS_PER_PLAYER-1:0] joystick2,
    joy_db15_responder_if.slave        joy,
    output logic                       frame_done,
    output logic [CNT_W-1:0]           bit_count,
    output logic                       overrun
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] load_sync_q, load_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   clk_rise;
    logic                   load_low;

    state_t                 state_q, state_d;
    logic [CHAIN_LEN-1:0]   chain_q, chain_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   over_q, over_d;

    logic [CHAIN_LEN-1:0]   image;
    logic [CHAIN_LEN-1:0]   shifted;

    // Synchronizer next values and edge detect on the last synced stage.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], joy.JOY_CLK};
        load_sync_d = {load_sync_q[SYNC_STAGES-2:0], joy.JOY_LOAD};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        clk_rise    = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
        load_low    = ~load_sync_q[SYNC_STAGES-1];
    end

    // Synchronizer flops idle high so release from reset never looks like an edge.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            clk_sync_q  <= '1;
            load_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            load_sync_q <= load_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    // Index 0 leaves first: player 1 LSB, then player 2; pressed reads as 0.
    always_comb begin
        image   = {~joystick2, ~joystick1};
        shifted = {FILL_BIT, chain_q[CHAIN_LEN-1:1]};
    end

    // Next-state logic; a low load strobe overrides any edge seen the same cycle.
    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        over_d  = over_q;
        if (load_low) begin
            state_d = ST_LOAD;
            chain_d = image;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        chain_d = shifted;
                        cnt_d   = cnt_q + CNT_ONE;
                        if (cnt_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (clk_rise) begin
                        chain_d = shifted;
                        over_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // Chain, counter and flags; the chain resets to "nothing pressed".
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= ST_LOAD;
            chain_q <= '1;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            over_q  <= over_d;
        end
    end

    assign joy.JOY_DATA = chain_q[0];
    assign frame_done   = done_q;
    assign bit_count    = cnt_q;
    assign overrun      = over_q;

endmodule
